// File: rtl/irq_timer_ctrl.sv
// ---------------------------------------------------------------------------
// irq_timer_ctrl
//
// System timer and interrupt controller for the CPU system-register window.
// Provides NUM_TIMERS independent countdown timers, each with its own
// prescaler (short or long period), one-shot or auto-reload mode and a
// status bit. A rising edge on ext_irq (DMA done) is latched into status
// bit 7. Status is masked into a single level IRQ towards the CPU.
// All timer, prescaler and bus state advances only on cycles where ce=1.
//
// Register map (addr):
//   2i   : timer i count   (write loads count+reload and restarts prescaler)
//   2i+1 : timer i control (bit0 enable, bit1 long prescale, bit2 auto-reload)
//   0xE  : mask   (bits [NUM_TIMERS-1:0] timers, bit 7 ext_irq)
//   0xF  : status (same layout; read acknowledges, write-1-to-clear)
//   other: read 0xFF, writes ignored
//
// Ports:
//   clk      system clock
//   reset_n  synchronous reset, active-low
//   ce       CPU-rate clock enable
//   cs       register select (sampled when ce=1)
//   we       1=write, 0=read
//   addr     register index
//   din      write data
//   dout     registered read data, held between reads
//   ext_irq  external interrupt request, rising edge latched
//   irq      registered level IRQ = |(status & mask)
// ---------------------------------------------------------------------------
module irq_timer_ctrl #(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 8,
  parameter int PRE_SHORT  = 256,
  parameter int PRE_LONG   = 16384
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       ext_irq,
  output logic       irq
);

  localparam int PW = $clog2(PRE_LONG);

  localparam logic [PW-1:0]    SHORT_M1 = PW'(PRE_SHORT - 1);
  localparam logic [PW-1:0]    LONG_M1  = PW'(PRE_LONG - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Implemented bits of the mask/status registers; the rest read as 0.
  localparam logic [7:0] STAT_BITS = 8'h80 | 8'((1 << NUM_TIMERS) - 1);

  localparam logic [3:0] ADDR_MASK   = 4'hE;
  localparam logic [3:0] ADDR_STATUS = 4'hF;

  // Bus strobes, qualified by the clock enable.
  logic wr_cyc;
  logic rd_cyc;
  assign wr_cyc = ce & cs & we;
  assign rd_cyc = ce & cs & ~we;

  // Per-timer state exported from the generate blocks for the read mux.
  logic [NUM_TIMERS-1:0][CNT_W-1:0] count_all;
  logic [NUM_TIMERS-1:0][2:0]       ctrl_all;
  logic [NUM_TIMERS-1:0]            expire_all;

  // -------------------------------------------------------------------------
  // Timers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      localparam logic [3:0] COUNT_ADDR = 4'(2 * gi);
      localparam logic [3:0] CTRL_ADDR  = 4'(2 * gi + 1);

      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;
      logic [CNT_W-1:0] reload_reg;
      logic [CNT_W-1:0] reload_next;
      logic [2:0]       ctrl_reg;
      logic [2:0]       ctrl_next;
      logic [PW-1:0]    pre_reg;
      logic [PW-1:0]    pre_next;
      logic [PW-1:0]    period_m1;
      logic             wr_count;
      logic             wr_ctrl;
      logic             tick;
      logic             expire;

      assign wr_count  = wr_cyc && (addr == COUNT_ADDR);
      assign wr_ctrl   = wr_cyc && (addr == CTRL_ADDR);
      assign period_m1 = ctrl_reg[1] ? LONG_M1 : SHORT_M1;

      always_comb begin
        count_next  = count_reg;
        reload_next = reload_reg;
        ctrl_next   = ctrl_reg;
        pre_next    = pre_reg;
        tick        = 1'b0;
        expire      = 1'b0;

        // Control writes never touch count or prescaler; the enable seen by
        // the countdown this cycle is the pre-write value.
        if (wr_ctrl) begin
          ctrl_next = din[2:0];
        end

        if (wr_count) begin
          // A count write overrides any tick landing on the same edge.
          count_next  = din[CNT_W-1:0];
          reload_next = din[CNT_W-1:0];
          pre_next    = period_m1;
          // Writing 0 to a running timer expires it immediately.
          expire      = ctrl_reg[0] && (din[CNT_W-1:0] == '0);
        end else if (ce && ctrl_reg[0]) begin
          if (pre_reg == '0) begin
            pre_next = period_m1;
            tick     = 1'b1;
          end else begin
            pre_next = pre_reg - PRE_ONE;
          end

          // A counter parked at 0 ignores ticks, so status is set only once.
          if (tick && (count_reg != '0)) begin
            if (count_reg == CNT_ONE) begin
              expire     = 1'b1;
              count_next = ctrl_reg[2] ? reload_reg : '0;
            end else begin
              count_next = count_reg - CNT_ONE;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          count_reg  <= '0;
          reload_reg <= '0;
          ctrl_reg   <= '0;
          pre_reg    <= '0;
        end else begin
          count_reg  <= count_next;
          reload_reg <= reload_next;
          ctrl_reg   <= ctrl_next;
          pre_reg    <= pre_next;
        end
      end

      assign count_all[gi]  = count_reg;
      assign ctrl_all[gi]   = ctrl_reg;
      assign expire_all[gi] = expire;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // External interrupt edge detect
  // -------------------------------------------------------------------------
  logic ext_prev_reg;
  logic ext_prev_next;
  logic ext_edge;

  assign ext_edge      = ce & ext_irq & ~ext_prev_reg;
  assign ext_prev_next = ce ? ext_irq : ext_prev_reg;

  // -------------------------------------------------------------------------
  // Mask / status
  // -------------------------------------------------------------------------
  logic [7:0] mask_reg;
  logic [7:0] mask_next;
  logic [7:0] status_reg;
  logic [7:0] status_next;
  logic [7:0] status_set;
  logic [7:0] status_clr;

  assign status_set = 8'(expire_all) | {ext_edge, 7'b0};

  always_comb begin
    mask_next  = mask_reg;
    status_clr = 8'h00;

    if (wr_cyc && (addr == ADDR_MASK)) begin
      mask_next = din & STAT_BITS;
    end

    // A status read acknowledges exactly the bits it returns.
    if (rd_cyc && (addr == ADDR_STATUS)) begin
      status_clr = status_reg;
    end
    if (wr_cyc && (addr == ADDR_STATUS)) begin
      status_clr = din & STAT_BITS;
    end

    // Set wins over a same-cycle acknowledge or W1C.
    status_next = (status_reg & ~status_clr) | status_set;
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'hFF;
    if (addr == ADDR_MASK) begin
      rd_data = mask_reg;
    end else if (addr == ADDR_STATUS) begin
      rd_data = status_reg;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (addr == 4'(2 * i)) begin
          rd_data = 8'(count_all[i]);
        end
        if (addr == 4'(2 * i + 1)) begin
          rd_data = {5'b0, ctrl_all[i]};
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shared registers
  // -------------------------------------------------------------------------
  logic [7:0] dout_reg;
  logic       irq_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_reg     <= 8'h00;
      status_reg   <= 8'h00;
      ext_prev_reg <= 1'b0;
      dout_reg     <= 8'hFF;
      irq_reg      <= 1'b0;
    end else begin
      mask_reg     <= mask_next;
      status_reg   <= status_next;
      ext_prev_reg <= ext_prev_next;
      if (rd_cyc) begin
        dout_reg <= rd_data;
      end
      // Built from the registered status, so irq trails a status change by
      // one clk regardless of ce.
      irq_reg <= |(status_reg & mask_reg);
    end
  end

  assign dout = dout_reg;
  assign irq  = irq_reg;

endmodule
